fft_twiddle_gen: RTL and testbench

//  Pipelined twiddle-factor generator for radix-2 N-point FFT/IFFT; generalises fixed 4-point Re/Im LUTs.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_twiddle_qrom.sv | 40 ++++
 rtl/fft_twiddle_gen.sv | 100 ++++++++++
 tb/tb_fft_twiddle_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the twiddle-factor generator.
// Quadrant encoding matches the top two bits of the phase index.
package fft_pkg;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

   localparam real PI     = 3.14159265358979323846;
   localparam int  TW_W   = 16;
   localparam int  TW_MAX = (1 << (TW_W - 1)) - 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int tw_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fft_twiddle_qrom.sv
// Quarter-wave cosine ROM, N/4+1 entries, two registered read ports.
// Entries are built at elaboration from real-valued cosine.
import fft_pkg::*;

module fft_twiddle_qrom #(
   parameter int N     = 64,
   parameter int WIDTH = 16,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   output logic [WIDTH-1:0] data_a,
   output logic [WIDTH-1:0] data_b
);

   localparam int DEPTH = N / 4 + 1;

   function automatic logic [WIDTH-1:0] cval(input int i);
      real x;
      x = $cos(2.0 * PI * i / N) * real'(tw_max(WIDTH));
      return WIDTH'($rtoi(x + 0.5));
   endfunction

   logic [WIDTH-1:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      localparam logic [WIDTH-1:0] CV = cval(i);
      assign rom[i] = CV;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         data_a <= rom[addr_a];
         data_b <= rom[addr_b];
      end
   end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Pipelined radix-2 twiddle generator: W = exp(-/+ j*2*pi*k*n/N).
// S1 phase product, S2 quadrant split + ROM, S3 sign/swap.
import fft_pkg::*;

module fft_twiddle_gen #(
   parameter int N     = 64,
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [clog2(N)-1:0]   in_k,
   input  logic [clog2(N)-1:0]   in_n,
   input  logic                  in_inv,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_re,
   output logic [WIDTH-1:0]      out_im,
   output logic [TAG_W-1:0]      out_tag
);

   localparam int L  = clog2(N);
   localparam int AW = L - 1;

   logic             adv;
   logic             v1, v2;
   logic             inv1, inv2;
   logic [L-1:0]     m1;
   logic [TAG_W-1:0] tag1, tag2;
   quad_t            q2;
   logic [AW-1:0]    ra, rb;
   logic [WIDTH-1:0] ca, cb;
   logic [WIDTH-1:0] cs, sn;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !rst;

   // r indexes cos from the quadrant start, N/4-r gives the matching sin
   assign ra = AW'(m1 & L'(N / 4 - 1));
   assign rb = AW'(N / 4) - ra;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (v2) begin
            out_re  <= cs;
            out_im  <= inv2 ? sn : -sn;
            out_tag <= tag2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         m1   <= in_k * in_n;
         inv1 <= in_inv;
         tag1 <= in_tag;
         q2   <= quad_t'(m1[L-1:L-2]);
         inv2 <= inv1;
         tag2 <= tag1;
      end
   end

   fft_twiddle_qrom #(
      .N     (N),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_qrom (
      .clk    (clk),
      .en     (adv),
      .addr_a (ra),
      .addr_b (rb),
      .data_a (ca),
      .data_b (cb)
   );

   always_comb begin
      cs = '0;
      sn = '0;
      unique case (q2)
         Q0: begin cs = ca;  sn = cb;  end
         Q1: begin cs = -cb; sn = ca;  end
         Q2: begin cs = -ca; sn = -cb; end
         Q3: begin cs = cb;  sn = -ca; end
      endcase
   end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed and swept checks of fft_twiddle_gen at N=64 and N=4.
// Scoreboard monitor checks values, order, latency and handshake.
module tb_fft_twiddle_gen;

   typedef struct {
      int re;
      int im;
      int tag;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_k = '0;
   logic [5:0]  in_n = '0;
   logic        in_inv = 1'b0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_re, out_im;
   logic [3:0]  out_tag;

   logic        in_valid4 = 1'b0;
   logic        in_ready4;
   logic [1:0]  in_k4 = '0;
   logic [1:0]  in_n4 = '0;
   logic        in_inv4 = 1'b0;
   logic [3:0]  in_tag4 = '0;
   logic        out_valid4;
   logic        out_ready4 = 1'b1;
   logic [15:0] out_re4, out_im4;
   logic [3:0]  out_tag4;

   int   nvec = 0;
   int   nerr = 0;
   int   cyc = 0;
   bit   mon_on = 0;
   bit   lat_on = 1;
   bit   rnd_on = 0;
   exp_t sb[$];

   fft_twiddle_gen #(.N(64), .WIDTH(16), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_k      (in_k),
      .in_n      (in_n),
      .in_inv    (in_inv),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_tag   (out_tag)
   );

   fft_twiddle_gen #(.N(4), .WIDTH(16), .TAG_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_k      (in_k4),
      .in_n      (in_n4),
      .in_inv    (in_inv4),
      .in_tag    (in_tag4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_re    (out_re4),
      .out_im    (out_im4),
      .out_tag   (out_tag4)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string t, input int obs, input int exp,
                      input int tol = 0);
      int d;
      nvec++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", t, obs, exp);
      end
   endtask

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   function automatic exp_t model(input int k, input int n, input int inv,
                                  input int tag, input int c);
      exp_t e;
      real  th;
      int   s;
      th    = 2.0 * 3.14159265358979323846 * ((k * n) % 64) / 64.0;
      e.re  = rnd(32767.0 * $cos(th));
      s     = rnd(32767.0 * $sin(th));
      e.im  = (inv != 0) ? s : -s;
      e.tag = tag;
      e.cyc = c;
      return e;
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("dup", 1, 0);
            end else begin
               chk("re", $signed(out_re), sb[0].re, 1);
               chk("im", $signed(out_im), sb[0].im, 1);
               chk("tag", int'(out_tag), sb[0].tag);
               if (out_ready) begin
                  if (lat_on) chk("lat", cyc - sb[0].cyc, 3);
                  void'(sb.pop_front());
               end
            end
         end
         if (in_valid && in_ready)
            sb.push_back(model(in_k, in_n, in_inv, in_tag, cyc));
         if (rst) sb.delete();
         chk("rdy", int'(in_ready),
             int'(!rst && (!out_valid || out_ready)));
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic send(input int k, input int n, input int inv, input int tag);
      in_valid = 1'b1;
      in_k     = 6'(k);
      in_n     = 6'(n);
      in_inv   = inv[0];
      in_tag   = 4'(tag);
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (in_ready) break;
         if (t > 200) begin
            chk("acc_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic hand64(input string t, input int k, input int n,
                         input int inv, input int er, input int ei);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_k     = 6'(k);
      in_n     = 6'(n);
      in_inv   = inv[0];
      in_tag   = 4'(k);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk({t, "_v"}, int'(out_valid), 1);
      chk({t, "_re"}, $signed(out_re), er);
      chk({t, "_im"}, $signed(out_im), ei);
   endtask

   task automatic hand4(input string t, input int k, input int n,
                        input int er, input int ei);
      @(posedge clk);
      #1;
      in_valid4 = 1'b1;
      in_k4     = 2'(k);
      in_n4     = 2'(n);
      in_inv4   = 1'b1;
      in_tag4   = 4'(k + 4 * n);
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk({t, "_v"}, int'(out_valid4), 1);
      chk({t, "_re"}, $signed(out_re4), er);
      chk({t, "_im"}, $signed(out_im4), ei);
      chk({t, "_tag"}, int'(out_tag4), k + 4 * n);
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ov", int'(out_valid), 0);
      chk("rst_re", int'(out_re), 0);
      chk("rst_im", int'(out_im), 0);
      chk("rst_tag", int'(out_tag), 0);
      chk("rst_rdy", int'(in_ready), 1);
      chk("rst_ov4", int'(out_valid4), 0);
      mon_on = 1;

      hand4("n4_11", 1, 1, 0, 32767);
      hand4("n4_13", 1, 3, 0, -32767);
      hand4("n4_21", 2, 1, -32767, 0);
      hand4("n4_31", 3, 1, 0, -32767);

      hand64("f_1_8", 1, 8, 0, 23170, -23170);
      hand64("f_1_16", 1, 16, 0, 0, -32767);
      hand64("f_3_0", 3, 0, 0, 32767, 0);
      hand64("f_8_8", 8, 8, 0, 32767, 0);
      hand64("i_1_24", 1, 24, 1, -23170, 23170);
      hand64("f_1_48", 1, 48, 0, 0, 32767);

      @(posedge clk);
      #1;
      for (int k = 0; k < 64; k++)
         for (int n = 0; n < 64; n++)
            for (int v = 0; v < 2; v++)
               send(k, n, v, (k * 128 + n * 2 + v) % 16);
      drain();

      lat_on = 0;
      rnd_on = 1;
      for (int i = 0; i < 300; i++)
         send($urandom_range(0, 63), $urandom_range(0, 63),
              $urandom_range(0, 1), i % 16);
      drain();
      rnd_on = 0;
      repeat (3) @(posedge clk);
      #1;
      lat_on = 1;

      send(5, 7, 0, 1);
      send(9, 3, 1, 2);
      send(11, 13, 0, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rdy", int'(in_ready), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ov", int'(out_valid), 0);
      repeat (5) @(posedge clk);
      #1;
      send(2, 3, 0, 9);
      drain();
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
